// File: rtl/spdif_lock_ctrl.sv
// S/PDIF receiver lock controller: sequences decoder reset, lock acquisition and settling,
// then unmutes audio and watches for lock or signal loss.
module spdif_lock_ctrl #(
  parameter logic [23:0] ACQ_TIMEOUT   = 24'd10_000_000,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1024,
  parameter logic [15:0] LOSS_TIMEOUT  = 16'd4096,
  parameter logic [7:0]  RST_CYCLES    = 8'd16
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       enable,
  input  logic       audio_locked,
  input  logic       edgedetect,
  output logic       dec_resetb,
  output logic       mute,
  output logic       locked_out,
  output logic       loss_err,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StResetDec = 3'd1,
    StAcquire  = 3'd2,
    StSettle   = 3'd3,
    StLocked   = 3'd4
  } state_e;

  localparam logic [23:0] AcqLast    = ACQ_TIMEOUT - 24'd1;
  localparam logic [23:0] SettleLast = {8'd0, SETTLE_CYCLES} - 24'd1;
  localparam logic [23:0] RstLast    = {16'd0, RST_CYCLES} - 24'd1;

  state_e      state_q, state_d;
  logic [23:0] phase_q, phase_d;
  logic [15:0] gap_q, gap_d;
  logic        edge_q;
  logic        rx_edge;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic        loss_d;
  logic        dec_resetb_q, mute_q, locked_q, loss_q;

  // Gap counter runs in every state so a dead line is already known on entering LOCKED.
  always_comb begin
    rx_edge = edgedetect ^ edge_q;
    gap_d   = gap_q;
    if (rx_edge) begin
      gap_d = '0;
    end else if (gap_q != LOSS_TIMEOUT) begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = 1'b0;
    retry_inc = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StResetDec;
        StResetDec: begin
          if (phase_q == RstLast) state_d = StAcquire;
        end
        StAcquire: begin
          if (audio_locked) begin
            state_d = StSettle;
          end else if (phase_q == AcqLast) begin
            state_d = StResetDec;
            retry_d = retry_inc;
          end
        end
        StSettle: begin
          if (!audio_locked) begin
            state_d = StAcquire;
          end else if (phase_q == SettleLast) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          // Unlock and gap timeout together still yield a single pulse.
          if (!audio_locked || (gap_q == LOSS_TIMEOUT)) begin
            state_d = StResetDec;
            loss_d  = 1'b1;
            retry_d = retry_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d == StIdle) retry_d = '0;
  end

  always_comb begin
    phase_d = phase_q;
    if (state_d != state_q) begin
      phase_d = '0;
    end else if ((state_q == StResetDec) || (state_q == StAcquire) || (state_q == StSettle)) begin
      phase_d = phase_q + 24'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      gap_q        <= '0;
      edge_q       <= 1'b0;
      retry_q      <= '0;
      dec_resetb_q <= 1'b0;
      mute_q       <= 1'b1;
      locked_q     <= 1'b0;
      loss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      gap_q        <= gap_d;
      edge_q       <= edgedetect;
      retry_q      <= retry_d;
      dec_resetb_q <= (state_d == StAcquire) || (state_d == StSettle) || (state_d == StLocked);
      mute_q       <= (state_d != StLocked);
      locked_q     <= (state_d == StLocked);
      loss_q       <= loss_d;
    end
  end

  assign dec_resetb = dec_resetb_q;
  assign mute       = mute_q;
  assign locked_out = locked_q;
  assign loss_err   = loss_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Bench for spdif_lock_ctrl: directed scenarios plus random stimulus, every cycle compared
// against a cycle-level behavioural model of the lock sequencing rules.
module tb_spdif_lock_ctrl;

  localparam int AcqT  = 100;
  localparam int SetT  = 10;
  localparam int LossT = 20;
  localparam int RstT  = 4;

  logic       clk_in = 1'b0;
  logic       resetb = 1'b0;
  logic       enable = 1'b0;
  logic       audio_locked = 1'b0;
  logic       edgedetect = 1'b0;
  logic       dec_resetb, mute, locked_out, loss_err;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  spdif_lock_ctrl #(
    .ACQ_TIMEOUT  (24'd100),
    .SETTLE_CYCLES(16'd10),
    .LOSS_TIMEOUT (16'd20),
    .RST_CYCLES   (8'd4)
  ) dut (
    .clk_in      (clk_in),
    .resetb      (resetb),
    .enable      (enable),
    .audio_locked(audio_locked),
    .edgedetect  (edgedetect),
    .dec_resetb  (dec_resetb),
    .mute        (mute),
    .locked_out  (locked_out),
    .loss_err    (loss_err),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state name, time spent in it, retry count and the cycle of the last rx edge.
  int m_state, m_tin, m_retry, m_cyc, m_last;
  bit m_loss, m_prev;
  bit auto_toggle = 1'b0;

  task automatic model_reset();
    m_state = 0; m_tin = 0; m_retry = 0; m_loss = 0; m_prev = 0; m_last = m_cyc;
  endtask

  task automatic model_step();
    int gap, nxt;
    bit seen;
    gap = m_cyc - m_last;
    if (gap > LossT) gap = LossT;
    seen = (edgedetect != m_prev);
    m_loss = 0;
    nxt = m_state;
    if (!enable) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: if (m_tin == RstT - 1) nxt = 2;
        2: if (audio_locked) nxt = 3;
           else if (m_tin == AcqT - 1) begin nxt = 1; if (m_retry < 15) m_retry++; end
        3: if (!audio_locked) nxt = 2;
           else if (m_tin == SetT - 1) nxt = 4;
        4: if (!audio_locked || gap == LossT) begin
             nxt = 1; m_loss = 1; if (m_retry < 15) m_retry++;
           end
        default: nxt = 0;
      endcase
    end
    if (nxt == 0) m_retry = 0;
    m_tin = (nxt == m_state) ? m_tin + 1 : 0;
    m_state = nxt;
    m_prev = edgedetect;
    m_cyc++;
    if (seen) m_last = m_cyc;
  endtask

  function automatic logic [10:0] m_pack();
    logic [2:0] s;
    logic [3:0] r;
    s = m_state[2:0];
    r = m_retry[3:0];
    return {s, (m_state >= 2), (m_state != 4), (m_state == 4), m_loss, r};
  endfunction

  wire [10:0] dut_pack = {state, dec_resetb, mute, locked_out, loss_err, retry_cnt};

  task automatic tick();
    if (auto_toggle && (m_cyc % 2 == 0)) edgedetect = ~edgedetect;
    if (resetb) model_step();
    else begin m_cyc++; m_last = m_cyc; end
    @(posedge clk_in);
    #1;
    check_eq("outputs", {21'd0, dut_pack}, {21'd0, m_pack()});
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int n = 0;
    while (state !== target[2:0] && n < budget) begin tick(); n++; end
    check_eq(tag, {29'd0, state}, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, {29'd0, state}, 0);
    check_eq({tag, "_dec_resetb"}, {31'd0, dec_resetb}, 0);
    check_eq({tag, "_mute"}, {31'd0, mute}, 1);
    check_eq({tag, "_locked_out"}, {31'd0, locked_out}, 0);
    check_eq({tag, "_loss_err"}, {31'd0, loss_err}, 0);
    check_eq({tag, "_retry"}, {28'd0, retry_cnt}, 0);
  endtask

  initial begin
    int rd_cnt, set_cnt, k, nret, last_entry, saved;
    logic [2:0] prev_st;
    m_cyc = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    model_reset();
    resetb = 1'b1;

    // Normal acquisition: lock appears after 30 cycles, rx edges every 2 cycles.
    auto_toggle = 1'b1;
    enable = 1'b1;
    rd_cnt = 0; set_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      audio_locked = (i >= 30);
      tick();
      if (state == 3'd1 && dec_resetb == 1'b0) rd_cnt++;
      if (state == 3'd3) set_cnt++;
    end
    check_eq("s31_rd_len", rd_cnt, RstT);
    check_eq("s31_settle_len", set_cnt, SetT);
    check_eq("s31_locked", {29'd0, state}, 4);
    check_eq("s31_unmuted", {31'd0, mute}, 0);

    // Signal loss: freeze rx edges while locked.
    auto_toggle = 1'b0;
    k = 0;
    while (!loss_err && k < 40) begin tick(); k++; end
    check_eq("s33_pulse", {31'd0, loss_err}, 1);
    check_eq("s33_state", {29'd0, state}, 1);
    check_eq("s33_mute", {31'd0, mute}, 1);
    check_eq("s33_timely", (k >= 19 && k <= 21), 1);
    auto_toggle = 1'b1;
    tick();
    check_eq("s33_one_cycle", {31'd0, loss_err}, 0);

    // Repeated acquire timeouts with lock never arriving.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    audio_locked = 1'b0;
    nret = 0; last_entry = 0; prev_st = state;
    for (int i = 0; i < 17 * (AcqT + RstT) + 10; i++) begin
      tick();
      if (state == 3'd1 && prev_st == 3'd2) begin
        nret++;
        check_eq("s32_retry", {28'd0, retry_cnt}, (nret > 15) ? 15 : nret);
        if (nret > 1) check_eq("s32_period", i - last_entry, AcqT + RstT);
        last_entry = i;
      end
      prev_st = state;
    end
    check_eq("s32_saturated", {28'd0, retry_cnt}, 15);

    // Lock drop on the fifth SETTLE cycle returns to ACQUIRE without a retry.
    wait_state("s34_acq", 2, 110);
    audio_locked = 1'b1;
    wait_state("s34_settle", 3, 5);
    repeat (4) tick();
    saved = retry_cnt;
    audio_locked = 1'b0;
    tick();
    check_eq("s34_back_acq", {29'd0, state}, 2);
    check_eq("s34_retry_same", {28'd0, retry_cnt}, saved);

    // Disable while locked clears retries and mutes.
    audio_locked = 1'b1;
    wait_state("s35_lock1", 4, 30);
    audio_locked = 1'b0;
    tick();
    audio_locked = 1'b1;
    wait_state("s35_lock2", 4, 40);
    enable = 1'b0;
    tick();
    check_eq("s35_idle", {29'd0, state}, 0);
    check_eq("s35_retry_clr", {28'd0, retry_cnt}, 0);
    check_eq("s35_mute", {31'd0, mute}, 1);

    // Asynchronous reset in the middle of ACQUIRE.
    enable = 1'b1;
    audio_locked = 1'b0;
    wait_state("s35_acq", 2, 10);
    repeat (3) tick();
    #2;
    resetb = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) tick();
    resetb = 1'b1;
    repeat (10) tick();

    // Random traffic.
    auto_toggle = 1'b0;
    k = 0;
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) audio_locked = ~audio_locked;
      if ($urandom_range(0, 99) == 0) k = ~k;
      if (k == 0 && $urandom_range(0, 1) == 1) edgedetect = ~edgedetect;
      if (resetb == 1'b0) resetb = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        resetb = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
